// File: rtl/beta_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beta_mem_pkg
// Description : Shared definitions for the BETA data-memory bus master.
//               Holds the FSM state encoding, the datapath word width and
//               the default access timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package beta_mem_pkg;

   localparam int BETA_WORD_W         = 32;
   localparam int BETA_TIMEOUT_CYCLES = 16;

   // FSM state encoding (2-bit, legacy-compatible constants)
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/beta_mem_timeout.sv
`default_nettype none
// ============================================================================
// Module      : beta_mem_timeout
// Description : Loadable up-counter that measures how long a bus access has
//               been waiting for an acknowledge.
//               Priority: clr > load > en.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               clr           - force count to zero
//               en            - increment count by one
//               load/load_val - load an arbitrary count value
//               count         - current count
//               expire        - count has reached TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module beta_mem_timeout
   import beta_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = BETA_TIMEOUT_CYCLES,
   parameter int CNT_W          = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             expire
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign expire = (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/beta_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : beta_mem_ctrl
// Description : Data-memory bus master for the BETA datapath. Turns the core's
//               MOE/MWR levels into req/ack bus cycles, stalls the core until
//               each access completes, and returns load data for WDSEL=2.
//               Optional macro BETA_MEM_ALIGN_CHECK_EN: misaligned requests
//               fault immediately without issuing a bus cycle.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               mem_rd, mem_wr    - core load / store request levels
//               addr, wdata       - byte address and store data from the core
//               rdata             - load result (held until the next load)
//               stall             - combinational pipeline freeze
//               mem_fault         - one-cycle fault pulse in DONE
//               bus_req/we/addr/wdata - registered bus request outputs
//               bus_ack, bus_rdata    - memory completion strobe and data
// Revision    : 1.0 - initial release
// ============================================================================
module beta_mem_ctrl
   import beta_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = BETA_TIMEOUT_CYCLES,
   parameter int CNT_W          = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_rd,
   input  logic                   mem_wr,
   input  logic [BETA_WORD_W-1:0] addr,
   input  logic [BETA_WORD_W-1:0] wdata,
   output logic [BETA_WORD_W-1:0] rdata,
   output logic                   stall,
   output logic                   mem_fault,
   output logic                   bus_req,
   output logic                   bus_we,
   output logic [BETA_WORD_W-1:0] bus_addr,
   output logic [BETA_WORD_W-1:0] bus_wdata,
   input  logic                   bus_ack,
   input  logic [BETA_WORD_W-1:0] bus_rdata
);

   logic [1:0]             state_d,     state_q;
   logic [BETA_WORD_W-1:0] rdata_d,     rdata_q;
   logic                   fault_d,     fault_q;
   logic                   bus_req_d,   bus_req_q;
   logic                   bus_we_d,    bus_we_q;
   logic [BETA_WORD_W-1:0] bus_addr_d,  bus_addr_q;
   logic [BETA_WORD_W-1:0] bus_wdata_d, bus_wdata_q;

   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_expire;
   logic [CNT_W-1:0] unused_cnt;
   logic             req_any;
   logic             misaligned;

   assign req_any = mem_rd | mem_wr;

`ifdef BETA_MEM_ALIGN_CHECK_EN
   assign misaligned = (addr[1:0] != 2'b00);
`else
   // Byte offset is dropped: the bus is word-addressed only.
   logic unused_addr_lo;
   assign unused_addr_lo = ^addr[1:0];
   assign misaligned     = 1'b0;
`endif

   beta_mem_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .load     (1'b0),
      .load_val ('0),
      .count    (unused_cnt),
      .expire   (cnt_expire)
   );

   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata_q;
      fault_d     = 1'b0;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               if (misaligned) begin
                  // No bus cycle; report the fault on the next (DONE) cycle.
                  state_d = ST_DONE;
                  fault_d = 1'b1;
                  if (!mem_wr) begin
                     rdata_d = '0;
                  end
               end else begin
                  state_d     = ST_REQ;
                  bus_req_d   = 1'b1;
                  bus_we_d    = mem_wr;   // rd & wr together is a store
                  bus_addr_d  = {addr[BETA_WORD_W-1:2], 2'b00};
                  bus_wdata_d = wdata;
                  cnt_clr     = 1'b1;
               end
            end
         end

         ST_REQ: begin
            cnt_en = 1'b1;
            // Ack is checked first so an ack on the last allowed cycle wins.
            if (bus_ack) begin
               state_d   = ST_DONE;
               bus_req_d = 1'b0;
               if (!bus_we_q) begin
                  rdata_d = bus_rdata;
               end
            end else if (cnt_expire) begin
               state_d   = ST_DONE;
               bus_req_d = 1'b0;
               fault_d   = 1'b1;
               if (!bus_we_q) begin
                  rdata_d = '0;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d   = ST_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rdata_q     <= '0;
         fault_q     <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         fault_q     <= fault_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

   // Stall covers the accepting IDLE cycle and every REQ cycle; DONE releases
   // the core so the instruction retires on that edge.
   assign stall     = ((state_q == ST_IDLE) && req_any) || (state_q == ST_REQ);
   assign rdata     = rdata_q;
   assign mem_fault = fault_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;

endmodule
`default_nettype wire
